descriptor_sequencer: RTL and testbench
=======================================

// Module: descriptor_sequencer
// PURPOSE
//  Walks an octave-partitioned keypoint list and, for each keypoint, drives an external histogram engine over a GRID x GRID array of SUBPATCH-sized subpatches.
//  Streams one histogram word per subpatch to descriptor memory over a valid/ready handshake.
//  Sits between keypoint detection (keypoint BRAM) and matching (descriptor BRAM).
//  Generalises octave count, grid size, keypoint BRAM latency, and clamps the patch to both image edges.
// PARAMETERS
//  DIMENSION      64    octave-0 image side; octave o side Do = DIMENSION>>o
//  NUM_OCTAVES    3     octaves in the keypoint list, 1..4
//  GRID           2     subpatches per patch side (GRID*GRID words per keypoint)
//  SUBPATCH       2     subpatch side in pixels (power of 2)
//  MAX_KEYPOINTS  1000  keypoint BRAM depth
//  KP_LATENCY     2     keypoint BRAM read latency in cycles, >=1
//  HIST_W         24    histogram word width
//  CW = $clog2(DIMENSION), KW = 2*CW+1, AW = $clog2(MAX_KEYPOINTS*GRID*GRID)
// PORTS
//  clk            in   1                  clock
//  rst_in         in   1                  synchronous active-high reset
//  start          in   1                  begin pass; honoured only in IDLE
//  done           out  1                  1-cycle pulse when pass ends
//  busy           out  1                  high whenever state != IDLE
//  key_read_addr  out  $clog2(MAX_KEYPOINTS)  keypoint BRAM address
//  keypoint_read  in   KW                 {x[CW-1:0], y[CW-1:0], level}, octave-o pixel units
//  hist_start     out  1                  1-cycle pulse, launches one subpatch histogram
//  hist_x,hist_y  out  CW each            subpatch top-left, octave-o units
//  hist_octave    out  2                  octave of current keypoint
//  hist_level     out  1                  level bit of current keypoint
//  hist_done      in   1                  1-cycle pulse; hist_bins valid this cycle
//  hist_bins      in   HIST_W             histogram result
//  desc_valid     out  1                  descriptor word valid
//  desc_ready     in   1                  descriptor sink accepts
//  desc_addr      out  AW                 descriptor write address
//  desc_data      out  HIST_W             registered copy of hist_bins
//  kp_count       out  $clog2(MAX_KEYPOINTS+1)  keypoints processed this pass
// BEHAVIOUR
//  Reset:
//   - state IDLE; all outputs 0; key_read_addr, desc_addr, kp_count and octave cleared.
//   - Reset mid-pass aborts immediately; a hist_done arriving after reset is ignored.
//  States:
//   - IDLE -> FETCH on start: clear addrs, counts and octave; latch nothing else.
//   - FETCH: hold key_read_addr KP_LATENCY cycles, then sample keypoint_read.
//     - Word == 0 is a sentinel. If octave < NUM_OCTAVES-1: octave++, addr++, stay in FETCH. Otherwise -> DONE.
//     - Nonzero word: latch x, y, level -> CLAMP.
//   - CLAMP, one cycle:
//     - ox = x - GRID*SUBPATCH/2, computed signed (CW+1 bits).
//     - Clamp ox to [0, Do - GRID*SUBPATCH]; same rule for oy.
//     - Reset subpatch indices i=j=0 -> ISSUE.
//   - ISSUE: hist_start=1 for one cycle; hist_x = ox + j*SUBPATCH, hist_y = oy + i*SUBPATCH -> WAIT.
//     - hist_x/y/octave/level stay stable from ISSUE until hist_done.
//   - WAIT: on hist_done, register hist_bins into desc_data, assert desc_valid -> WRITE.
//   - WRITE: hold desc_valid, desc_data and desc_addr stable until desc_ready.
//     - On the accept cycle (valid & ready): desc_addr++, drop valid.
//     - Then advance j; on j wrap, advance i (row-major order).
//     - More subpatches -> ISSUE. Else kp_count++ and:
//       - if key_read_addr == MAX_KEYPOINTS-1 -> DONE;
//       - else addr++ -> FETCH.
//   - DONE: done=1 for one cycle -> IDLE.
//  Rules:
//   - start outside IDLE is ignored.
//   - hist_done outside WAIT is ignored.
//   - Latency: the first hist_start follows start by KP_LATENCY+2 cycles.
//   - The next hist_start follows the accepting desc_ready by exactly 1 cycle.
//   - desc_addr wraps at 2^AW; the pass never produces more than MAX_KEYPOINTS*GRID*GRID words.
// TESTING
//  - Defaults; oct0 kp x=10,y=20,lvl=1 then sentinels x3 -> hist (8,18),(10,18),(8,20),(10,20), lvl 1, oct 0; desc_addr 0..3; kp_count=1; done.
//  - Oct0 kp x=1,y=0 -> origin (0,0). Oct2 (Do=16) kp x=15,y=15 -> origin (12,12); subpatches (12,12),(14,12),(12,14),(14,14).
//  - List {kpA,0,0,kpB,0}: A on octave 0; octave 1 empty; B on octave 2 read from addr 3 -> 8 words, kp_count=2, done once.
//  - desc_ready low 5 cycles after hist_done -> desc_valid, data, addr held; no hist_start until 1 cycle after ready.
//  - rst_in in WAIT, then late hist_done -> outputs 0, stays IDLE, no desc_valid.
//  - start pulsed mid-pass ignored. MAX_KEYPOINTS=4 with no sentinels -> 16 words, then done.

Source files
------------

// File: rtl/descriptor_sequencer_if.sv
// rtl/descriptor_sequencer_if.sv - keypoint read, histogram engine and descriptor stream bus of the sequencer
interface descriptor_sequencer_if #(
  parameter int DIMENSION     = 64,
  parameter int GRID          = 2,
  parameter int MAX_KEYPOINTS = 1000,
  parameter int HIST_W        = 24
);
  localparam int CW  = $clog2(DIMENSION);
  localparam int KW  = 2 * CW + 1;
  localparam int KAW = $clog2(MAX_KEYPOINTS);
  localparam int AW  = $clog2(MAX_KEYPOINTS * GRID * GRID);

  // keypoint BRAM read port
  logic [KAW-1:0]    key_read_addr;
  logic [KW-1:0]     keypoint_read;

  // histogram engine launch / result
  logic              hist_start;
  logic [CW-1:0]     hist_x;
  logic [CW-1:0]     hist_y;
  logic [1:0]        hist_octave;
  logic              hist_level;
  logic              hist_done;
  logic [HIST_W-1:0] hist_bins;

  // descriptor memory write stream
  logic              desc_valid;
  logic              desc_ready;
  logic [AW-1:0]     desc_addr;
  logic [HIST_W-1:0] desc_data;

  modport master (
    output key_read_addr,
    input  keypoint_read,
    output hist_start,
    output hist_x,
    output hist_y,
    output hist_octave,
    output hist_level,
    input  hist_done,
    input  hist_bins,
    output desc_valid,
    input  desc_ready,
    output desc_addr,
    output desc_data
  );

  modport slave (
    input  key_read_addr,
    output keypoint_read,
    input  hist_start,
    input  hist_x,
    input  hist_y,
    input  hist_octave,
    input  hist_level,
    output hist_done,
    output hist_bins,
    input  desc_valid,
    output desc_ready,
    input  desc_addr,
    input  desc_data
  );
endinterface

// File: rtl/descriptor_sequencer.sv
// rtl/descriptor_sequencer.sv - walks the keypoint list and streams one histogram word per subpatch
module descriptor_sequencer #(
  parameter int DIMENSION     = 64,
  parameter int NUM_OCTAVES   = 3,
  parameter int GRID          = 2,
  parameter int SUBPATCH      = 2,
  parameter int MAX_KEYPOINTS = 1000,
  parameter int KP_LATENCY    = 2,
  parameter int HIST_W        = 24
) (
  input  logic                               clk,
  input  logic                               rst_in,
  input  logic                               start,
  output logic                               done,
  output logic                               busy,
  output logic [$clog2(MAX_KEYPOINTS+1)-1:0] kp_count,
  descriptor_sequencer_if.master             bus
);
  localparam int CW       = $clog2(DIMENSION);
  localparam int KAW      = $clog2(MAX_KEYPOINTS);
  localparam int AW       = $clog2(MAX_KEYPOINTS * GRID * GRID);
  localparam int CNTW     = $clog2(MAX_KEYPOINTS + 1);
  localparam int GW       = (GRID > 1) ? $clog2(GRID) : 1;
  localparam int LW       = (KP_LATENCY > 1) ? $clog2(KP_LATENCY) : 1;
  localparam int SW       = CW + 2;
  localparam int SP_SHIFT = $clog2(SUBPATCH);

  localparam logic signed [SW-1:0] HALF_PATCH = SW'(GRID * SUBPATCH / 2);
  localparam logic signed [SW-1:0] PATCH      = SW'(GRID * SUBPATCH);
  localparam logic [LW-1:0]        LAT_LAST   = LW'(KP_LATENCY - 1);
  localparam logic [GW-1:0]        GRID_LAST  = GW'(GRID - 1);
  localparam logic [1:0]           OCT_LAST   = 2'(NUM_OCTAVES - 1);
  localparam logic [KAW-1:0]       ADDR_LAST  = KAW'(MAX_KEYPOINTS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CLAMP,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  logic [LW-1:0]     lat_cnt;
  logic [1:0]        octave;
  logic [CW-1:0]     kp_x;
  logic [CW-1:0]     kp_y;
  logic              kp_level;
  logic [CW-1:0]     ox;
  logic [CW-1:0]     oy;
  logic [GW-1:0]     sub_row;
  logic [GW-1:0]     sub_col;
  logic [KAW-1:0]    key_addr;
  logic              issue_pulse;
  logic [CW-1:0]     sub_x;
  logic [CW-1:0]     sub_y;
  logic              word_valid;
  logic [AW-1:0]     word_addr;
  logic [HIST_W-1:0] word_data;

  logic signed [SW-1:0] side;
  logic signed [SW-1:0] hi_lim;
  logic [CW-1:0]        ox_c;
  logic [CW-1:0]        oy_c;
  logic [GW-1:0]        row_next;
  logic [GW-1:0]        col_next;
  logic                 last_sub;
  logic [CW-1:0]        off_x;
  logic [CW-1:0]        off_y;

  // Patch origin is centred on the keypoint, then pushed back inside the octave image.
  function automatic logic [CW-1:0] clamp_axis(input logic [CW-1:0] c, input logic signed [SW-1:0] hi);
    logic signed [SW-1:0] o;
    o = $signed({2'b00, c}) - HALF_PATCH;
    if (o[SW-1])
      clamp_axis = '0;
    else if (o > hi)
      clamp_axis = hi[CW-1:0];
    else
      clamp_axis = o[CW-1:0];
  endfunction

  // Clamped patch origin for the latched keypoint in its octave.
  always_comb begin
    side   = $signed(SW'(DIMENSION) >> octave);
    hi_lim = side - PATCH;
    ox_c   = clamp_axis(kp_x, hi_lim);
    oy_c   = clamp_axis(kp_y, hi_lim);
  end

  // Next subpatch in row-major order and its pixel offset within the patch.
  always_comb begin
    col_next = (sub_col == GRID_LAST) ? '0 : sub_col + GW'(1);
    row_next = (sub_col == GRID_LAST) ? sub_row + GW'(1) : sub_row;
    last_sub = (sub_col == GRID_LAST) && (sub_row == GRID_LAST);
    off_x    = CW'(col_next) << SP_SHIFT;
    off_y    = CW'(row_next) << SP_SHIFT;
  end

  // Sequencer FSM; every output is a register updated on the transition that enters its state.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      octave      <= '0;
      kp_x        <= '0;
      kp_y        <= '0;
      kp_level    <= 1'b0;
      ox          <= '0;
      oy          <= '0;
      sub_row     <= '0;
      sub_col     <= '0;
      key_addr    <= '0;
      issue_pulse <= 1'b0;
      sub_x       <= '0;
      sub_y       <= '0;
      word_valid  <= 1'b0;
      word_addr   <= '0;
      word_data   <= '0;
      kp_count    <= '0;
      done        <= 1'b0;
    end else begin
      issue_pulse <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            key_addr  <= '0;
            word_addr <= '0;
            kp_count  <= '0;
            octave    <= '0;
            lat_cnt   <= '0;
          end
        end
        FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            if (bus.keypoint_read == '0) begin
              // a zero word closes the current octave's section of the list
              if (octave == OCT_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                octave   <= octave + 2'd1;
                key_addr <= key_addr + KAW'(1);
              end
            end else begin
              kp_x     <= bus.keypoint_read[2*CW:CW+1];
              kp_y     <= bus.keypoint_read[CW:1];
              kp_level <= bus.keypoint_read[0];
              state    <= CLAMP;
            end
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        CLAMP: begin
          ox          <= ox_c;
          oy          <= oy_c;
          sub_x       <= ox_c;
          sub_y       <= oy_c;
          sub_row     <= '0;
          sub_col     <= '0;
          issue_pulse <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.hist_done) begin
            word_data  <= bus.hist_bins;
            word_valid <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (bus.desc_ready) begin
            word_valid <= 1'b0;
            word_addr  <= word_addr + AW'(1);
            if (last_sub) begin
              kp_count <= kp_count + CNTW'(1);
              if (key_addr == ADDR_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                key_addr <= key_addr + KAW'(1);
                lat_cnt  <= '0;
                state    <= FETCH;
              end
            end else begin
              sub_col     <= col_next;
              sub_row     <= row_next;
              sub_x       <= ox + off_x;
              sub_y       <= oy + off_y;
              issue_pulse <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy              = (state != IDLE);
  assign bus.key_read_addr = key_addr;
  assign bus.hist_start    = issue_pulse;
  assign bus.hist_x        = sub_x;
  assign bus.hist_y        = sub_y;
  assign bus.hist_octave   = octave;
  assign bus.hist_level    = kp_level;
  assign bus.desc_valid    = word_valid;
  assign bus.desc_addr     = word_addr;
  assign bus.desc_data     = word_data;
endmodule

// File: tb/tb_descriptor_sequencer.sv
// tb/tb_descriptor_sequencer.sv - directed self-checking bench for descriptor_sequencer
`timescale 1ns/1ps
module tb_descriptor_sequencer;
  localparam int KW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_in;
  logic       start, start_b;
  logic       done, busy, done_b, busy_b;
  logic [9:0] kp_count;
  logic [2:0] kp_count_b;

  descriptor_sequencer_if #(.DIMENSION(64), .GRID(2), .MAX_KEYPOINTS(1000), .HIST_W(24)) bus_a ();
  descriptor_sequencer_if #(.DIMENSION(64), .GRID(2), .MAX_KEYPOINTS(4),    .HIST_W(24)) bus_b ();

  descriptor_sequencer #(
    .DIMENSION(64), .NUM_OCTAVES(3), .GRID(2), .SUBPATCH(2),
    .MAX_KEYPOINTS(1000), .KP_LATENCY(2), .HIST_W(24)
  ) u_dut (
    .clk(clk), .rst_in(rst_in), .start(start), .done(done), .busy(busy),
    .kp_count(kp_count), .bus(bus_a.master)
  );

  descriptor_sequencer #(
    .DIMENSION(64), .NUM_OCTAVES(3), .GRID(2), .SUBPATCH(2),
    .MAX_KEYPOINTS(4), .KP_LATENCY(2), .HIST_W(24)
  ) u_small (
    .clk(clk), .rst_in(rst_in), .start(start_b), .done(done_b), .busy(busy_b),
    .kp_count(kp_count_b), .bus(bus_b.master)
  );

  // keypoint BRAMs: one address register, so data is ready one cycle after the address
  logic [KW-1:0] mem_a [0:15];
  logic [KW-1:0] mem_b [0:3];
  logic [9:0]    addr_q_a;
  logic [1:0]    addr_q_b;
  always @(posedge clk) begin
    addr_q_a <= bus_a.key_read_addr;
    addr_q_b <= bus_b.key_read_addr;
  end
  assign bus_a.keypoint_read = mem_a[addr_q_a[3:0]];
  assign bus_b.keypoint_read = mem_b[addr_q_b];

  logic        ready_a, man_done;
  logic [23:0] man_bins;
  logic        auto_done, auto_done_b;
  logic [23:0] auto_bins, auto_bins_b;
  bit          hist_auto;
  assign bus_a.hist_done  = auto_done | man_done;
  assign bus_a.hist_bins  = man_done ? man_bins : auto_bins;
  assign bus_a.desc_ready = ready_a;
  assign bus_b.hist_done  = auto_done_b;
  assign bus_b.hist_bins  = auto_bins_b;
  assign bus_b.desc_ready = 1'b1;

  function automatic logic [23:0] mk_bins(input logic [1:0] o, input logic l, input logic [5:0] x, input logic [5:0] y);
    return {4'h5, o, l, 5'h00, x, y};
  endfunction

  function automatic logic [KW-1:0] mk_kp(input int x, input int y, input int l);
    return {6'(x), 6'(y), 1'(l)};
  endfunction

  logic [5:0]  hs_x[$], hs_y[$], hb_x[$], hb_y[$];
  logic [1:0]  hs_oct[$];
  logic        hs_lvl[$];
  int          hs_cyc[$], da_cyc[$];
  logic [11:0] da_addr[$];
  logic [23:0] da_data[$];
  int          done_cnt = 0, done_cnt_b = 0, acc_b = 0;
  logic [3:0]  last_addr_b = '0;

  // histogram engine + bus monitor for the default DUT
  initial begin
    int cnt;
    logic [23:0] pend;
    cnt = 0;
    pend = '0;
    auto_done = 1'b0;
    auto_bins = '0;
    forever begin
      @(negedge clk);
      auto_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          auto_done = 1'b1;
          auto_bins = pend;
        end
      end
      if (bus_a.hist_start) begin
        hs_x.push_back(bus_a.hist_x);
        hs_y.push_back(bus_a.hist_y);
        hs_oct.push_back(bus_a.hist_octave);
        hs_lvl.push_back(bus_a.hist_level);
        hs_cyc.push_back(cyc);
        if (hist_auto) begin
          cnt  = 2;
          pend = mk_bins(bus_a.hist_octave, bus_a.hist_level, bus_a.hist_x, bus_a.hist_y);
        end
      end
      if (bus_a.desc_valid && bus_a.desc_ready) begin
        da_addr.push_back(bus_a.desc_addr);
        da_data.push_back(bus_a.desc_data);
        da_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  // histogram engine + bus monitor for the MAX_KEYPOINTS=4 DUT
  initial begin
    int cnt;
    logic [23:0] pend;
    cnt = 0;
    pend = '0;
    auto_done_b = 1'b0;
    auto_bins_b = '0;
    forever begin
      @(negedge clk);
      auto_done_b = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          auto_done_b = 1'b1;
          auto_bins_b = pend;
        end
      end
      if (bus_b.hist_start) begin
        cnt  = 2;
        pend = mk_bins(bus_b.hist_octave, bus_b.hist_level, bus_b.hist_x, bus_b.hist_y);
        hb_x.push_back(bus_b.hist_x);
        hb_y.push_back(bus_b.hist_y);
      end
      if (bus_b.desc_valid && bus_b.desc_ready) begin
        acc_b++;
        last_addr_b = bus_b.desc_addr;
      end
      if (done_b) done_cnt_b++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int hs0, da0, done0, start_cyc;

  task automatic do_reset();
    @(posedge clk); #1;
    rst_in = 1'b1; start = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; man_done = 1'b0; man_bins = '0; hist_auto = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
  endtask

  task automatic load_a(input logic [KW-1:0] w0, input logic [KW-1:0] w1, input logic [KW-1:0] w2,
                        input logic [KW-1:0] w3, input logic [KW-1:0] w4);
    for (int k = 0; k < 16; k++) mem_a[k] = '0;
    mem_a[0] = w0; mem_a[1] = w1; mem_a[2] = w2; mem_a[3] = w3; mem_a[4] = w4;
  endtask

  task automatic mark();
    hs0 = hs_x.size(); da0 = da_addr.size(); done0 = done_cnt;
  endtask

  // one pass from a start pulse to done; mid >= 0 re-pulses start that many cycles in
  task automatic run_a(input string tag, input int mid);
    bit fin;
    fin = 1'b0;
    mark();
    @(posedge clk); #1 start = 1'b1; start_cyc = cyc;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1 start = (k == mid);
      if (done_cnt > done0) begin
        fin = 1'b1;
        break;
      end
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_finished"}, 32'(fin), 32'd1);
  endtask

  task automatic check_subs(input string tag, input int base, input int ox, input int oy,
                            input logic [1:0] o, input logic l);
    int ex, ey;
    for (int s = 0; s < 4; s++) begin
      ex = ox + (s % 2) * 2;
      ey = oy + (s / 2) * 2;
      if (hs_x.size() > hs0 + base + s && da_data.size() > da0 + base + s) begin
        check({tag, "_hist_x"}, 32'(hs_x[hs0+base+s]), 32'(ex));
        check({tag, "_hist_y"}, 32'(hs_y[hs0+base+s]), 32'(ey));
        check({tag, "_octave"}, 32'(hs_oct[hs0+base+s]), 32'(o));
        check({tag, "_level"}, 32'(hs_lvl[hs0+base+s]), 32'(l));
        check({tag, "_desc_addr"}, 32'(da_addr[da0+base+s]), 32'(base + s));
        check({tag, "_desc_data"}, 32'(da_data[da0+base+s]), 32'(mk_bins(o, l, 6'(ex), 6'(ey))));
      end else begin
        check({tag, "_missing_word"}, 32'(da_data.size() - da0), 32'(base + s + 1));
      end
    end
  endtask

  initial begin
    bit ok;
    for (int k = 0; k < 4; k++) mem_b[k] = '0;
    load_a('0, '0, '0, '0, '0);
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_desc_valid", 32'(bus_a.desc_valid), 32'd0);
    check("rst_hist_start", 32'(bus_a.hist_start), 32'd0);
    check("rst_key_addr", 32'(bus_a.key_read_addr), 32'd0);
    check("rst_desc_addr", 32'(bus_a.desc_addr), 32'd0);
    check("rst_kp_count", 32'(kp_count), 32'd0);
    check("rst_small_busy", 32'(busy_b), 32'd0);

    // single octave-0 keypoint followed by three sentinels
    do_reset();
    load_a(mk_kp(10, 20, 1), '0, '0, '0, '0);
    run_a("t1", -1);
    check("t1_words", 32'(da_addr.size() - da0), 32'd4);
    check_subs("t1", 0, 8, 18, 2'd0, 1'b1);
    check("t1_kp_count", 32'(kp_count), 32'd1);
    check("t1_done_once", 32'(done_cnt - done0), 32'd1);
    check("t1_desc_addr_end", 32'(bus_a.desc_addr), 32'd4);
    check("t1_key_addr_end", 32'(bus_a.key_read_addr), 32'd3);
    check("t1_busy_end", 32'(busy), 32'd0);
    if (hs_cyc.size() > hs0 + 1 && da_cyc.size() > da0) begin
      check("t1_first_latency", 32'(hs_cyc[hs0] - start_cyc), 32'd4);
      check("t1_next_issue", 32'(hs_cyc[hs0+1] - da_cyc[da0]), 32'd1);
    end else begin
      check("t1_timing_missing", 32'(hs_cyc.size() - hs0), 32'd4);
    end

    // clamp at the low image edge
    do_reset();
    load_a(mk_kp(1, 0, 0), '0, '0, '0, '0);
    run_a("t2a", -1);
    check_subs("t2a", 0, 0, 0, 2'd0, 1'b0);

    // clamp at the high edge of octave 2 (side 16)
    do_reset();
    load_a('0, '0, mk_kp(15, 15, 0), '0, '0);
    run_a("t2b", -1);
    check_subs("t2b", 0, 12, 12, 2'd2, 1'b0);
    check("t2b_words", 32'(da_addr.size() - da0), 32'd4);

    // keypoint on octave 0, empty octave 1, keypoint on octave 2
    do_reset();
    load_a(mk_kp(30, 30, 0), '0, '0, mk_kp(5, 9, 1), '0);
    run_a("t3", -1);
    check("t3_words", 32'(da_addr.size() - da0), 32'd8);
    check_subs("t3a", 0, 28, 28, 2'd0, 1'b0);
    check_subs("t3b", 4, 3, 7, 2'd2, 1'b1);
    check("t3_kp_count", 32'(kp_count), 32'd2);
    check("t3_done_once", 32'(done_cnt - done0), 32'd1);

    // descriptor sink stalls: word, address and valid must hold with no new launch
    do_reset();
    load_a(mk_kp(10, 20, 1), '0, '0, '0, '0);
    mark();
    ready_a = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus_a.desc_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_valid_seen", 32'(ok), 32'd1);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(bus_a.desc_valid), 32'd1);
      check("t4_hold_data", 32'(bus_a.desc_data), 32'(mk_bins(2'd0, 1'b1, 6'd8, 6'd18)));
      check("t4_hold_addr", 32'(bus_a.desc_addr), 32'd0);
      check("t4_no_issue", 32'(bus_a.hist_start), 32'd0);
    end
    @(posedge clk); #1 ready_a = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done_cnt > done0) begin
        ok = 1'b1;
        break;
      end
    end
    check("t4_finished", 32'(ok), 32'd1);
    check("t4_words", 32'(da_addr.size() - da0), 32'd4);
    check_subs("t4", 0, 8, 18, 2'd0, 1'b1);
    if (hs_cyc.size() > hs0 + 1 && da_cyc.size() > da0)
      check("t4_issue_after_accept", 32'(hs_cyc[hs0+1] - da_cyc[da0]), 32'd1);
    else
      check("t4_timing_missing", 32'(hs_cyc.size() - hs0), 32'd4);

    // a start pulse in the middle of a pass changes nothing
    do_reset();
    load_a(mk_kp(10, 20, 1), '0, '0, '0, '0);
    run_a("t5", 8);
    check("t5_words", 32'(da_addr.size() - da0), 32'd4);
    check("t5_done_once", 32'(done_cnt - done0), 32'd1);
    check("t5_kp_count", 32'(kp_count), 32'd1);
    check_subs("t5", 0, 8, 18, 2'd0, 1'b1);

    // reset while waiting on the histogram engine, then a late hist_done
    do_reset();
    load_a(mk_kp(10, 20, 1), '0, '0, '0, '0);
    hist_auto = 1'b0;
    mark();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (hs_x.size() > hs0) begin
        ok = 1'b1;
        break;
      end
    end
    check("t6_issue_seen", 32'(ok), 32'd1);
    @(posedge clk); #1 rst_in = 1'b1;
    @(posedge clk); #1 rst_in = 1'b0; man_done = 1'b1; man_bins = 24'hABCDEF;
    @(posedge clk); #1 man_done = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_desc_valid", 32'(bus_a.desc_valid), 32'd0);
    check("t6_desc_data", 32'(bus_a.desc_data), 32'd0);
    check("t6_hist_x", 32'(bus_a.hist_x), 32'd0);
    check("t6_key_addr", 32'(bus_a.key_read_addr), 32'd0);
    check("t6_words", 32'(da_addr.size() - da0), 32'd0);
    hist_auto = 1'b1;

    // four keypoints filling a MAX_KEYPOINTS=4 list with no sentinel
    mem_b[0] = mk_kp(4, 4, 0);
    mem_b[1] = mk_kp(8, 8, 1);
    mem_b[2] = mk_kp(20, 40, 0);
    mem_b[3] = mk_kp(62, 62, 1);
    do_reset();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (done_cnt_b > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    check("t7_finished", 32'(ok), 32'd1);
    check("t7_words", 32'(acc_b), 32'd16);
    check("t7_last_addr", 32'(last_addr_b), 32'd15);
    check("t7_kp_count", 32'(kp_count_b), 32'd4);
    check("t7_done_once", 32'(done_cnt_b), 32'd1);
    if (hb_x.size() == 16) begin
      check("t7_kp1_x", 32'(hb_x[4]), 32'd6);
      check("t7_kp2_y", 32'(hb_y[8]), 32'd38);
      check("t7_kp3_x", 32'(hb_x[12]), 32'd60);
      check("t7_kp3_last_y", 32'(hb_y[15]), 32'd62);
    end else begin
      check("t7_issue_count", 32'(hb_x.size()), 32'd16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
